rstation_append: RTL and testbench
==================================

# rstation_append

Reservation-station block of the Tomasulo pipeline, placed between the issue stage and the add/mul functional units. It accepts one issued instruction per cycle and stores it in a 2-entry add station or a 2-entry mul station. Operand values or ROB tags come from the register-status lookup, and waiting operands are captured from the common data bus (CDB). Ready entries are dispatched to the matching functional unit through a valid/ready handshake.

## Interface
- `DATA_W`, 16: operand width.
- `ROB_W`, 3: ROB index/tag width (8-entry ROB).
- `REG_W`, 4: architectural register index width.
- `FUNC_W`, 4: opcode width.
- `clk1`, in, 1: the only clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `count`, in, 1: append request; 1 means the issue stage allocated a ROB slot this cycle.
- `rs1`, `rs2`, `rd`, in, REG_W: source and destination register indices. `rd` is carried for bookkeeping only.
- `func`, in, FUNC_W: opcode. `0000` ADD, `0001` SUB (add class); `0010` MUL, `0011` DIV (mul class). All other values are illegal.
- `rob_ind`, in, ROB_W: ROB tag of the appended instruction.
- `rs1_busy`, `rs2_busy`, in, 1: source register is awaiting a result.
- `rs1_tag`, `rs2_tag`, in, ROB_W: producing ROB tag, valid only when the matching busy bit is 1.
- `rs1_val`, `rs2_val`, in, DATA_W: register value, valid only when the matching busy bit is 0.
- `cdb_valid`, in, 1; `cdb_tag`, in, ROB_W; `cdb_data`, in, DATA_W: result broadcast.
- `add_valid`, out, 1; `add_ready`, in, 1; `add_func`, out, FUNC_W; `add_op1`, `add_op2`, out, DATA_W; `add_tag`, out, ROB_W: add-unit dispatch port.
- `mul_valid`, `mul_ready`, `mul_func`, `mul_op1`, `mul_op2`, `mul_tag`: the same port set for the mul unit.
- `add_count`, `mul_count`, out, 2: number of occupied entries in each station (0–2).
- `append_drop`, out, 1: one-cycle pulse when an append is rejected.

## Operation
- Each entry holds: busy, func, rob tag, rd, Vj, Qj, Rj (operand j ready), Vk, Qk, Rk.
- **Append.** When `count` = 1 and `func` is legal:
  - The instruction is written into the lowest-indexed free entry of its class.
  - Operand j comes from `rs1_*`: if not busy, Rj = 1 and Vj = `rs1_val`. If busy, Rj = 0 and Qj = `rs1_tag`.
  - Operand k comes from `rs2_*` in the same way.
- **Same-cycle CDB forward on append.** If `cdb_valid` is 1 and `cdb_tag` equals a busy operand's tag, that operand is stored ready with value `cdb_data`.
- **Rejected append.** If the target station is full or `func` is illegal, nothing is written and `append_drop` = 1 for that cycle.
- **CDB capture.** Every cycle with `cdb_valid` = 1, each busy entry with an operand where R = 0 and Q = `cdb_tag` sets R = 1 and V = `cdb_data`.
- **Dispatch.**
  - `add_valid` = 1 when any add entry has busy, Rj and Rk all set.
  - The selected entry is the lowest-indexed ready one. Its func, Vj, Vk and tag drive the `add_*` outputs.
  - On `add_valid` && `add_ready`, that entry's busy bit is cleared.
  - The mul station behaves identically.
- `add_count` / `mul_count` are the registered popcount of the busy bits.

## Timing
- **Reset.** All busy bits are cleared. `add_count` = `mul_count` = 0, `add_valid` = `mul_valid` = 0, `append_drop` = 0, and all data outputs are 0.
- **Append to dispatch.** An append at edge N is visible in the counts after N. The earliest `*_valid` is the cycle after N when both operands are ready. An entry is never dispatched in the cycle it is appended.
- **CDB to dispatch.** A CDB capture at edge N allows dispatch in the cycle after N.
- Dispatch outputs are combinational from registered entry state.
- `*_valid` stays asserted and data stays stable until `*_ready` is 1.
- **Full station, append plus dispatch in the same cycle.** The freed slot is not reusable that cycle. Fullness is evaluated on the pre-edge busy bits, so the append is dropped.
- **Append plus CDB in the same cycle.** The forwarding rule above applies, so no wakeup is lost.
- **Duplicate CDB tags.** Two entries waiting on the same tag both wake on one broadcast.
- **`rst` during operation.** `rst` overrides append, capture and dispatch in that cycle.

## Structure
- Shared package `tomasulo_pkg`:
  - func encodings (`FUNC_ADD`, `FUNC_SUB`, `FUNC_MUL`, `FUNC_DIV`);
  - width constants;
  - the RS entry struct type;
  - a class-decode function (add/mul/illegal).
- One sub-module, `rs_bank`, instantiated twice (add and mul). It holds N entries and implements free-slot search, CDB capture, ready select and the dispatch handshake.
- The top level decodes the class, routes the append, and ORs the drop conditions into `append_drop`.

## Test plan
- Reset, then append ADD with rs1 = 2 (val 5) and rs2 = 3 (val 7), rob 1, `add_ready` = 1 → the next cycle shows `add_valid` = 1, op1 = 5, op2 = 7, tag = 1, and `add_count` returns to 0 after the handshake.
- Append MUL with rs1 busy, tag 4, and rs2 value 3; two cycles later send CDB tag 4, data 9 → `mul_valid` in the cycle after the CDB, with op1 = 9 and op2 = 3.
- Append ADD with rs2 busy, tag 6, in the same cycle as CDB tag 6, data 11 → the entry is ready immediately and dispatches the next cycle with op2 = 11.
- Fill the add station (two appends, `add_ready` = 0) and append a third ADD → `append_drop` pulses and `add_count` stays 2. A MUL append in the same state is accepted.
- Two add entries both ready with `add_ready` = 1 → entry 0 dispatches first and entry 1 on the following cycle. With `add_ready` held at 0, the outputs stay stable.
- Append with `func` = `0101` → `append_drop` = 1 and both counts are unchanged. Asserting `rst` with both stations full → the next cycle has both counts at 0 and both valids at 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reservation-station slice.
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int ROB_W  = 3;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {
        CLS_ADD     = 2'd0,
        CLS_MUL     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } fclass_e;

    typedef struct packed {
        logic              busy;
        logic [FUNC_W-1:0] func;
        logic [ROB_W-1:0]  tag;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] vj;
        logic [ROB_W-1:0]  qj;
        logic              rj;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  qk;
        logic              rk;
    } rs_entry_t;

    function automatic fclass_e func_class(input logic [FUNC_W-1:0] f);
        case (f)
            FUNC_ADD, FUNC_SUB: return CLS_ADD;
            FUNC_MUL, FUNC_DIV: return CLS_MUL;
            default:            return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/rs_bank.sv
// N-entry reservation station: free-slot search, CDB wakeup, ready select
// and valid/ready dispatch to one functional unit.
module rs_bank
    import tomasulo_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              app_valid,
    input  rs_entry_t         app_entry,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [FUNC_W-1:0] disp_func,
    output logic [DATA_W-1:0] disp_op1,
    output logic [DATA_W-1:0] disp_op2,
    output logic [ROB_W-1:0]  disp_tag,
    output logic [CNT_W-1:0]  occ
);

    rs_entry_t        ents     [N];
    rs_entry_t        ents_nxt [N];
    logic [N-1:0]     rdy;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic             any_rdy;
    logic             fire;
    logic             do_app;
    logic [CNT_W-1:0] occ_nxt;

    always_comb begin
        free_idx = '0;
        full     = 1'b1;
        rdy_idx  = '0;
        any_rdy  = 1'b0;
        rdy      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rdy[i] = ents[i].busy && ents[i].rj && ents[i].rk;
            if (!ents[i].busy) begin
                free_idx = IDX_W'(i);
                full     = 1'b0;
            end
            if (rdy[i]) begin
                rdy_idx = IDX_W'(i);
                any_rdy = 1'b1;
            end
        end
    end

    // A stalled offer keeps its entry even if a lower-indexed one wakes up,
    // so the outputs stay stable until the unit accepts.
    always_comb begin
        sel_idx    = (lock && rdy[lock_idx]) ? lock_idx : rdy_idx;
        disp_valid = any_rdy;
        disp_func  = disp_valid ? ents[sel_idx].func : '0;
        disp_op1   = disp_valid ? ents[sel_idx].vj   : '0;
        disp_op2   = disp_valid ? ents[sel_idx].vk   : '0;
        disp_tag   = disp_valid ? ents[sel_idx].tag  : '0;
    end

    assign fire   = disp_valid && disp_ready;
    assign do_app = app_valid && !full;

    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < N; i++) begin
            ents_nxt[i] = ents[i];
            if (cdb_valid && ents[i].busy) begin
                if (!ents[i].rj && ents[i].qj == cdb_tag) begin
                    ents_nxt[i].rj = 1'b1;
                    ents_nxt[i].vj = cdb_data;
                end
                if (!ents[i].rk && ents[i].qk == cdb_tag) begin
                    ents_nxt[i].rk = 1'b1;
                    ents_nxt[i].vk = cdb_data;
                end
            end
            if (fire && sel_idx == IDX_W'(i)) begin
                ents_nxt[i].busy = 1'b0;
            end
            // Only a slot free before the edge is a target; a slot freed by
            // dispatch this cycle is not reused until the next one.
            if (do_app && free_idx == IDX_W'(i)) begin
                ents_nxt[i] = app_entry;
            end
            occ_nxt = occ_nxt + CNT_W'(ents_nxt[i].busy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ents[i] <= '0;
            end
            occ      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                ents[i] <= ents_nxt[i];
            end
            occ      <= occ_nxt;
            lock     <= disp_valid && !disp_ready;
            lock_idx <= sel_idx;
        end
    end

endmodule

// File: rtl/rstation_append.sv
// Reservation-station front end: class decode, operand setup with same-cycle
// CDB forwarding, and routing of appends into the add and mul banks.
module rstation_append
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int ROB_W  = tomasulo_pkg::ROB_W,
    parameter int REG_W  = tomasulo_pkg::REG_W,
    parameter int FUNC_W = tomasulo_pkg::FUNC_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              count,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [ROB_W-1:0]  rob_ind,
    input  logic              rs1_busy,
    input  logic              rs2_busy,
    input  logic [ROB_W-1:0]  rs1_tag,
    input  logic [ROB_W-1:0]  rs2_tag,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              add_valid,
    input  logic              add_ready,
    output logic [FUNC_W-1:0] add_func,
    output logic [DATA_W-1:0] add_op1,
    output logic [DATA_W-1:0] add_op2,
    output logic [ROB_W-1:0]  add_tag,
    output logic              mul_valid,
    input  logic              mul_ready,
    output logic [FUNC_W-1:0] mul_func,
    output logic [DATA_W-1:0] mul_op1,
    output logic [DATA_W-1:0] mul_op2,
    output logic [ROB_W-1:0]  mul_tag,
    output logic [1:0]        add_count,
    output logic [1:0]        mul_count,
    output logic              append_drop
);

    fclass_e   cls;
    rs_entry_t app_entry;
    logic      fwd_j;
    logic      fwd_k;
    logic      add_full;
    logic      mul_full;
    logic      add_app;
    logic      mul_app;
    logic      unused_idx;

    // Register indices are resolved upstream by the register-status lookup.
    assign unused_idx = ^{rs1, rs2};

    assign cls = func_class(func);

    always_comb begin
        fwd_j = rs1_busy && cdb_valid && (cdb_tag == rs1_tag);
        fwd_k = rs2_busy && cdb_valid && (cdb_tag == rs2_tag);

        app_entry      = '0;
        app_entry.busy = 1'b1;
        app_entry.func = func;
        app_entry.tag  = rob_ind;
        app_entry.rd   = rd;
        app_entry.rj   = !rs1_busy || fwd_j;
        app_entry.vj   = rs1_busy ? (fwd_j ? cdb_data : '0) : rs1_val;
        app_entry.qj   = rs1_busy ? rs1_tag : '0;
        app_entry.rk   = !rs2_busy || fwd_k;
        app_entry.vk   = rs2_busy ? (fwd_k ? cdb_data : '0) : rs2_val;
        app_entry.qk   = rs2_busy ? rs2_tag : '0;
    end

    assign add_app = count && (cls == CLS_ADD);
    assign mul_app = count && (cls == CLS_MUL);

    assign append_drop = !rst && count &&
                         ((cls == CLS_ILLEGAL) ||
                          (cls == CLS_ADD && add_full) ||
                          (cls == CLS_MUL && mul_full));

    rs_bank #(.N(2)) u_add_bank (
        .clk        (clk1),
        .rst        (rst),
        .app_valid  (add_app),
        .app_entry  (app_entry),
        .full       (add_full),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .disp_valid (add_valid),
        .disp_ready (add_ready),
        .disp_func  (add_func),
        .disp_op1   (add_op1),
        .disp_op2   (add_op2),
        .disp_tag   (add_tag),
        .occ        (add_count)
    );

    rs_bank #(.N(2)) u_mul_bank (
        .clk        (clk1),
        .rst        (rst),
        .app_valid  (mul_app),
        .app_entry  (app_entry),
        .full       (mul_full),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .disp_valid (mul_valid),
        .disp_ready (mul_ready),
        .disp_func  (mul_func),
        .disp_op1   (mul_op1),
        .disp_op2   (mul_op2),
        .disp_tag   (mul_tag),
        .occ        (mul_count)
    );

endmodule

// File: tb/tb_rstation_append.sv
// Scoreboard bench for rstation_append: directed appends push expected
// dispatches; a negedge monitor pops and compares on every handshake.
module tb_rstation_append;
    import tomasulo_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        count;
    logic [3:0]  rs1, rs2, rd, func;
    logic [2:0]  rob_ind;
    logic        rs1_busy, rs2_busy;
    logic [2:0]  rs1_tag, rs2_tag;
    logic [15:0] rs1_val, rs2_val;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        add_valid, add_ready, mul_valid, mul_ready;
    logic [3:0]  add_func, mul_func;
    logic [15:0] add_op1, add_op2, mul_op1, mul_op2;
    logic [2:0]  add_tag, mul_tag;
    logic [1:0]  add_count, mul_count;
    logic        append_drop;

    rstation_append dut (
        .clk1(clk1), .rst(rst), .count(count),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .rob_ind(rob_ind),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .add_valid(add_valid), .add_ready(add_ready), .add_func(add_func),
        .add_op1(add_op1), .add_op2(add_op2), .add_tag(add_tag),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_func(mul_func),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_tag(mul_tag),
        .add_count(add_count), .mul_count(mul_count),
        .append_drop(append_drop)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  func;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  tag;
        int          cyc;
    } exp_t;

    exp_t add_q[$];
    exp_t mul_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic push_add(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] t, input int c);
        exp_t e;
        e.func = f; e.op1 = a; e.op2 = b; e.tag = t; e.cyc = c;
        add_q.push_back(e);
    endtask

    task automatic push_mul(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] t, input int c);
        exp_t e;
        e.func = f; e.op1 = a; e.op2 = b; e.tag = t; e.cyc = c;
        mul_q.push_back(e);
    endtask

    always @(negedge clk1) begin
        exp_t e;
        if (add_valid === 1'b1 && add_ready === 1'b1) begin
            if (add_q.size() == 0) begin
                n_total++;
                $display("FAIL add_unexpected: tag=%0d op1=%0d at cycle %0d, none required", add_tag, add_op1, cyc);
            end else begin
                e = add_q.pop_front();
                chk("add_func", 32'(add_func), 32'(e.func));
                chk("add_op1",  32'(add_op1),  32'(e.op1));
                chk("add_op2",  32'(add_op2),  32'(e.op2));
                chk("add_tag",  32'(add_tag),  32'(e.tag));
                chk("add_cycle", cyc, e.cyc);
            end
        end
        if (mul_valid === 1'b1 && mul_ready === 1'b1) begin
            if (mul_q.size() == 0) begin
                n_total++;
                $display("FAIL mul_unexpected: tag=%0d op1=%0d at cycle %0d, none required", mul_tag, mul_op1, cyc);
            end else begin
                e = mul_q.pop_front();
                chk("mul_func", 32'(mul_func), 32'(e.func));
                chk("mul_op1",  32'(mul_op1),  32'(e.op1));
                chk("mul_op2",  32'(mul_op2),  32'(e.op2));
                chk("mul_tag",  32'(mul_tag),  32'(e.tag));
                chk("mul_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic mid();
        @(negedge clk1);
    endtask

    task automatic idle();
        count = 1'b0; func = FUNC_ADD; rob_ind = '0; rd = '0;
        rs1 = '0; rs2 = '0;
        rs1_busy = 1'b0; rs2_busy = 1'b0; rs1_tag = '0; rs2_tag = '0;
        rs1_val = '0; rs2_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic app(input logic [3:0] f,
                       input logic b1, input logic [2:0] t1, input logic [15:0] v1,
                       input logic b2, input logic [2:0] t2, input logic [15:0] v2,
                       input logic [2:0] rob);
        count = 1'b1; func = f; rob_ind = rob;
        rs1 = 4'd2; rs2 = 4'd3; rd = 4'd1;
        rs1_busy = b1; rs1_tag = t1; rs1_val = v1;
        rs2_busy = b2; rs2_tag = t2; rs2_val = v2;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        idle();
        rst = 1'b1; add_ready = 1'b0; mul_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mid();
        chk("rst_add_count", 32'(add_count), 0);
        chk("rst_mul_count", 32'(mul_count), 0);
        chk("rst_add_valid", 32'(add_valid), 0);
        chk("rst_mul_valid", 32'(mul_valid), 0);
        chk("rst_drop",      32'(append_drop), 0);
        chk("rst_add_op1",   32'(add_op1), 0);
        chk("rst_mul_tag",   32'(mul_tag), 0);

        // ADD with both operands ready dispatches the next cycle
        tick();
        add_ready = 1'b1;
        app(FUNC_ADD, 0, 0, 16'd5, 0, 0, 16'd7, 3'd1);
        push_add(FUNC_ADD, 16'd5, 16'd7, 3'd1, cyc + 1);
        mid();
        chk("s1_drop", 32'(append_drop), 0);
        chk("s1_count_pre", 32'(add_count), 0);
        tick(); idle();
        mid();
        chk("s1_count_held", 32'(add_count), 1);
        tick();
        mid();
        chk("s1_count_after", 32'(add_count), 0);
        chk("s1_valid_after", 32'(add_valid), 0);

        // MUL waiting on tag 4, woken by CDB two cycles later
        tick();
        mul_ready = 1'b1;
        app(FUNC_MUL, 1, 3'd4, 16'd0, 0, 0, 16'd3, 3'd2);
        tick(); idle();
        mid();
        chk("s2_mul_wait_valid", 32'(mul_valid), 0);
        chk("s2_mul_count", 32'(mul_count), 1);
        tick();
        cdb(3'd4, 16'd9);
        push_mul(FUNC_MUL, 16'd9, 16'd3, 3'd2, cyc + 1);
        mid();
        chk("s2_mul_cdb_valid", 32'(mul_valid), 0);
        tick(); idle();
        tick();
        mid();
        chk("s2_mul_count_after", 32'(mul_count), 0);

        // SUB appended in the same cycle tag 6 is broadcast
        tick();
        app(FUNC_SUB, 0, 0, 16'd4, 1, 3'd6, 16'd0, 3'd3);
        cdb(3'd6, 16'd11);
        push_add(FUNC_SUB, 16'd4, 16'd11, 3'd3, cyc + 1);
        tick(); idle();
        tick();
        mid();
        chk("s3_add_count", 32'(add_count), 0);

        // Fill the add station, drop a third ADD, accept a MUL
        tick();
        add_ready = 1'b0; mul_ready = 1'b0;
        app(FUNC_ADD, 0, 0, 16'd10, 0, 0, 16'd20, 3'd4);
        tick();
        app(FUNC_SUB, 0, 0, 16'd30, 0, 0, 16'd40, 3'd5);
        mid();
        chk("s4_count_one", 32'(add_count), 1);
        tick();
        app(FUNC_ADD, 0, 0, 16'd1, 0, 0, 16'd2, 3'd6);
        mid();
        chk("s4_full_drop", 32'(append_drop), 1);
        chk("s4_full_count", 32'(add_count), 2);
        tick();
        app(FUNC_MUL, 0, 0, 16'd2, 0, 0, 16'd3, 3'd7);
        mid();
        chk("s4_mul_drop", 32'(append_drop), 0);
        chk("s4_count_stays", 32'(add_count), 2);
        tick(); idle();
        mid();
        chk("s4_mul_count", 32'(mul_count), 1);
        chk("s4_stall_valid", 32'(add_valid), 1);
        chk("s4_stall_op1", 32'(add_op1), 10);
        chk("s4_stall_op2", 32'(add_op2), 20);
        chk("s4_stall_tag", 32'(add_tag), 4);
        tick();
        mid();
        chk("s4_stable_op1", 32'(add_op1), 10);
        chk("s4_stable_tag", 32'(add_tag), 4);
        // dispatch frees entry 0 but the same-cycle append still drops
        tick();
        add_ready = 1'b1;
        app(FUNC_ADD, 0, 0, 16'd50, 0, 0, 16'd60, 3'd0);
        push_add(FUNC_ADD, 16'd10, 16'd20, 3'd4, cyc);
        push_add(FUNC_SUB, 16'd30, 16'd40, 3'd5, cyc + 1);
        mid();
        chk("s4_fire_drop", 32'(append_drop), 1);
        tick(); idle();
        mid();
        chk("s4_after_fire_count", 32'(add_count), 1);
        tick();
        mid();
        chk("s4_drained_count", 32'(add_count), 0);
        mul_ready = 1'b1;
        push_mul(FUNC_MUL, 16'd2, 16'd3, 3'd7, cyc);
        tick();
        mul_ready = 1'b0;
        mid();
        chk("s4_mul_drained", 32'(mul_count), 0);

        // Two entries waiting on tag 5 both wake on one broadcast
        tick();
        add_ready = 1'b0;
        app(FUNC_ADD, 1, 3'd5, 16'd0, 0, 0, 16'd1, 3'd1);
        tick();
        app(FUNC_SUB, 0, 0, 16'd2, 1, 3'd5, 16'd0, 3'd2);
        tick(); idle();
        cdb(3'd5, 16'd100);
        mid();
        chk("s5_pre_cdb_valid", 32'(add_valid), 0);
        tick(); idle();
        add_ready = 1'b1;
        push_add(FUNC_ADD, 16'd100, 16'd1, 3'd1, cyc);
        push_add(FUNC_SUB, 16'd2, 16'd100, 3'd2, cyc + 1);
        tick();
        tick();
        add_ready = 1'b0;
        mid();
        chk("s5_count", 32'(add_count), 0);

        // Stalled offer on entry 1 keeps priority when entry 0 wakes
        tick();
        app(FUNC_ADD, 1, 3'd2, 16'd0, 0, 0, 16'd1, 3'd3);
        tick();
        app(FUNC_ADD, 0, 0, 16'd7, 0, 0, 16'd8, 3'd4);
        tick(); idle();
        cdb(3'd2, 16'd9);
        mid();
        chk("s6_offer_tag", 32'(add_tag), 4);
        tick(); idle();
        mid();
        chk("s6_locked_tag", 32'(add_tag), 4);
        chk("s6_locked_op1", 32'(add_op1), 7);
        tick();
        add_ready = 1'b1;
        push_add(FUNC_ADD, 16'd7, 16'd8, 3'd4, cyc);
        push_add(FUNC_ADD, 16'd9, 16'd1, 3'd3, cyc + 1);
        tick();
        tick();
        add_ready = 1'b0;

        // Both stations full, illegal func, then reset with a pending append
        app(FUNC_ADD, 0, 0, 16'd1, 0, 0, 16'd1, 3'd1);
        tick();
        app(FUNC_SUB, 0, 0, 16'd2, 0, 0, 16'd2, 3'd2);
        tick();
        app(FUNC_MUL, 0, 0, 16'd3, 0, 0, 16'd3, 3'd3);
        tick();
        app(FUNC_DIV, 0, 0, 16'd4, 0, 0, 16'd4, 3'd4);
        tick();
        app(4'b0101, 0, 0, 16'd5, 0, 0, 16'd5, 3'd5);
        mid();
        chk("s7_illegal_drop", 32'(append_drop), 1);
        tick(); idle();
        mid();
        chk("s7_add_count", 32'(add_count), 2);
        chk("s7_mul_count", 32'(mul_count), 2);
        chk("s7_mul_valid", 32'(mul_valid), 1);
        chk("s7_mul_func", 32'(mul_func), 32'(FUNC_MUL));
        tick();
        rst = 1'b1;
        app(FUNC_ADD, 0, 0, 16'd6, 0, 0, 16'd6, 3'd6);
        tick();
        rst = 1'b0; idle();
        mid();
        chk("s7_rst_add_count", 32'(add_count), 0);
        chk("s7_rst_mul_count", 32'(mul_count), 0);
        chk("s7_rst_add_valid", 32'(add_valid), 0);
        chk("s7_rst_mul_valid", 32'(mul_valid), 0);
        tick(); tick();

        chk("add_q_drained", 32'(add_q.size()), 0);
        chk("mul_q_drained", 32'(mul_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
